// File: rtl/sr_latch_bank_ctrl.sv
// sr_latch_bank_ctrl
//   Drives set/reset pulses into a bank of cross-coupled SR latches on
//   behalf of two requesters (A and B) sharing the bank through a
//   round-robin arbiter. Each transaction runs IDLE -> PULSE -> SETTLE ->
//   CHECK -> IDLE. After the pulse has settled, the latch Q is read back
//   and a sticky error is raised if the write did not take. An
//   out-of-range index skips straight to CHECK and flags an error.
//   S and R are registered and derived from a single one-hot select gated
//   by the captured op, so S=R=1 can never reach a latch.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req_a/req_b  requests, held high until the matching ack
//   op_a/op_b    1 = set latch, 0 = reset latch
//   idx_a/idx_b  target latch index
//   ack_a/ack_b  one-cycle completion pulse to the grantee
//   q_in         Q feedback from the latch bank
//   s_out/r_out  per-latch S and R drives (registered)
//   busy         high while a transaction is in flight
//   err          sticky write-failure / bad-index flag
module sr_latch_bank_ctrl #(
   parameter int NUM_LATCH  = 4,
   parameter int IDX_W      = 2,
   parameter int PULSE_CYC  = 2,
   parameter int SETTLE_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_a,
   input  logic                 op_a,
   input  logic [IDX_W-1:0]     idx_a,
   output logic                 ack_a,
   input  logic                 req_b,
   input  logic                 op_b,
   input  logic [IDX_W-1:0]     idx_b,
   output logic                 ack_b,
   input  logic [NUM_LATCH-1:0] q_in,
   output logic [NUM_LATCH-1:0] s_out,
   output logic [NUM_LATCH-1:0] r_out,
   output logic                 busy,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

   localparam int unsigned NL_U = 32'(NUM_LATCH);

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 op_q, op_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 gnt_b_q, gnt_b_d;
   logic                 rr_b_q, rr_b_d;
   logic                 err_q, err_d;
   logic [NUM_LATCH-1:0] s_q, s_d, r_q, r_d;
   logic [NUM_LATCH-1:0] sel_d;
   logic                 q_bit;
   logic                 pick_b;

   function automatic logic in_range(input logic [IDX_W-1:0] i);
      return 32'(i) < NL_U;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      idx_d   = idx_q;
      gnt_b_d = gnt_b_q;
      rr_b_d  = rr_b_q;
      err_d   = err_q;
      // B wins only if A is absent or B holds the round-robin priority.
      pick_b  = req_b & (~req_a | rr_b_q);
      q_bit   = 1'b0;
      for (int i = 0; i < NUM_LATCH; i++) begin
         if (idx_q == IDX_W'(i)) q_bit = q_in[i];
      end

      case (state_q)
         IDLE: begin
            if (req_a | req_b) begin
               op_d    = pick_b ? op_b : op_a;
               idx_d   = pick_b ? idx_b : idx_a;
               gnt_b_d = pick_b;
               rr_b_d  = ~pick_b;
               cnt_d   = 4'd0;
               state_d = in_range(idx_d) ? PULSE : CHECK;
            end
         end
         PULSE: begin
            if (cnt_q == 4'(PULSE_CYC - 1)) begin
               cnt_d   = 4'd0;
               state_d = SETTLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         SETTLE: begin
            if (cnt_q == 4'(SETTLE_CYC - 1)) begin
               cnt_d   = 4'd0;
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         CHECK: begin
            if (!in_range(idx_q) || (q_bit != op_q)) err_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Drives are computed from the next state so they line up with
      // PULSE cycle-for-cycle while still coming straight from flops.
      sel_d = '0;
      for (int i = 0; i < NUM_LATCH; i++) begin
         sel_d[i] = (idx_d == IDX_W'(i));
      end
      s_d = '0;
      r_d = '0;
      if (state_d == PULSE) begin
         if (op_d) s_d = sel_d;
         else      r_d = sel_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         gnt_b_q <= 1'b0;
         rr_b_q  <= 1'b0;
         err_q   <= 1'b0;
         s_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_b_q <= gnt_b_d;
         rr_b_q  <= rr_b_d;
         err_q   <= err_d;
         s_q     <= s_d;
         r_q     <= r_d;
      end
   end

   // Captured request payload; only meaningful while busy.
   always_ff @(posedge clk) begin
      op_q  <= op_d;
      idx_q <= idx_d;
   end

   assign s_out = s_q;
   assign r_out = r_q;
   assign busy  = (state_q != IDLE);
   assign ack_a = (state_q == CHECK) & ~gnt_b_q;
   assign ack_b = (state_q == CHECK) &  gnt_b_q;
   assign err   = err_q;

endmodule

// File: doc/sr_latch_bank_ctrl.md
Name: sr_latch_bank_ctrl

Overview:
- Sequences set/reset pulses into a bank of cross-coupled SR latches.
- Two requesters share the bank through a round-robin arbiter.
- The block guarantees the S=R=1 invalid condition can never reach any latch.
- After each pulse it reads the latch Q back and flags any write that did not take.

Parameters:
- NUM_LATCH, 4, number of latches in the bank (2..16).
- IDX_W, 2, width of the latch index (covers NUM_LATCH-1).
- PULSE_CYC, 2, clock cycles the S or R line is held high (1..15).
- SETTLE_CYC, 1, idle cycles after a pulse before Q is checked (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A request; held high until ack_a.
- op_a  in  1  requester A operation: 1=set, 0=reset.
- idx_a  in  IDX_W  requester A target latch.
- ack_a  out  1  one-cycle completion pulse to A.
- req_b, op_b, idx_b, ack_b  same as A, for requester B.
- q_in  in  NUM_LATCH  Q feedback from the latch bank.
- s_out  out  NUM_LATCH  per-latch S drive.
- r_out  out  NUM_LATCH  per-latch R drive.
- busy  out  1  high while a transaction is in flight.
- err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (asynchronous, immediate, including mid-pulse):
  - s_out=0, r_out=0, ack_a=ack_b=0, busy=0, err=0.
  - State returns to IDLE.
  - Round-robin pointer is set to favour A.
- States: IDLE -> PULSE -> SETTLE -> CHECK -> IDLE.
- IDLE:
  - Samples req_a/req_b each edge.
  - One request: grant it.
  - Both requests: grant the requester not granted last (A first after reset).
  - On grant, capture op, idx and the grantee, toggle the RR pointer, and go to PULSE.
- idx >= NUM_LATCH:
  - Skip PULSE and SETTLE and go straight to CHECK.
  - Set err; no s_out/r_out activity.
- PULSE (PULSE_CYC cycles):
  - op=1: s_out[idx]=1.
  - op=0: r_out[idx]=1.
  - All other bits are 0.
- SETTLE (SETTLE_CYC cycles): s_out=r_out=0.
- CHECK (1 cycle):
  - Pulse ack of the grantee for exactly this cycle.
  - If q_in[idx] != op, set err.
  - Next state is IDLE.
- busy is high in PULSE, SETTLE and CHECK; low in IDLE.
- Latency, with the grant on edge 0:
  - Pulse occupies cycles 1..PULSE_CYC.
  - Settle occupies the next SETTLE_CYC cycles.
  - ack asserts in cycle PULSE_CYC+SETTLE_CYC+1.
  - Default latency is 4 cycles from grant to ack.
- Handshake:
  - op/idx are captured at grant; later changes are ignored until ack.
  - A requester whose req is still high in the cycle after its ack is treated as making a new request.
  - The non-granted requester waits; its ack stays 0.
- Invariants checked at every edge:
  - (s_out & r_out) == 0.
  - popcount(s_out | r_out) <= 1.
  - s_out/r_out are registered outputs (glitch-free).
  - ack_a & ack_b == 0.
- Back-to-back:
  - IDLE always lasts at least 1 cycle between transactions.
  - There is therefore at least 1 cycle of s_out=r_out=0 between different latch writes, in addition to SETTLE.
- Setting an already-set latch is legal: the pulse is still issued, and err stays 0 if Q=1.

Test Plan:
- Reset then req_a=1, op_a=1, idx_a=2, q_in[2] rising after the pulse -> s_out=4'b0100 for 2 cycles, ack_a on cycle 4 after grant, err=0, r_out=0 throughout.
- req_a and req_b both high from reset, A: set idx0, B: reset idx3 -> A served first (s_out=0001), then after the IDLE cycle B served (r_out=1000); then both requests re-raised -> A first again (RR alternation A,B,A,B).
- Request set idx1 with q_in[1] held 0 -> ack asserted as normal, err=1 and stays 1 across later good transactions until rst.
- NUM_LATCH=3, idx_a=3 -> no s_out/r_out activity, ack_a one cycle after grant, err=1.
- Assert rst during the second PULSE cycle -> s_out/r_out drop to 0 in the same cycle (asynchronously), busy=0, no ack; next request executes normally.
- Randomised 1000 requests with changing idx/op during busy -> s_out & r_out never both high on any bit; latched op/idx match the values at grant.
